intersection_controller: RTL and testbench
==========================================

Name: intersection_controller

Overview:
- Master sequencer for a two-road (NS/EW) signalised intersection.
- Cycles the vehicle phases and generates the per-phase `master_timer` countdown.
- Latches pedestrian push-button requests and drives `ns_walk_enable` / `ew_walk_enable`.
- Sits directly upstream of the two pedestrian_light instances: `master_timer` plus the walk enable feed each crossing's display and lamps.

Parameters:
- GREEN_TIME, 45, green phase length in ticks (legal 1..127)
- YELLOW_TIME, 4, yellow phase length in ticks (legal 1..127)
- ALL_RED_TIME, 2, all-red clearance length in ticks (legal 1..127)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-clk-wide 1 Hz strobe; all timing counts ticks
- ns_ped_req  input  1  NS crossing button, level or pulse
- ew_ped_req  input  1  EW crossing button, level or pulse
- preempt  input  1  emergency preemption request (present only with PREEMPT_EN)
- ns_light  output  3  {red,yellow,green}, one-hot
- ew_light  output  3  {red,yellow,green}, one-hot
- ns_walk_enable  output  1  to the NS pedestrian_light enable
- ew_walk_enable  output  1  to the EW pedestrian_light enable
- master_timer  output  7  ticks remaining in the current phase, counting down to 0
- ped_pending  output  2  {ew,ns} latched requests not yet served

Behaviour:
- All outputs are registered. Every change is visible the clk after its cause.
- State sequence: NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> NS_GREEN.
- Phase timing:
  - On entry to a phase, `master_timer` loads (duration-1).
  - It decrements by 1 on each tick while greater than 0.
  - A tick while `master_timer`==0 advances to the next phase and loads that phase's (duration-1) in the same clk.
  - A phase therefore lasts exactly its duration in ticks.
  - The timer never wraps below 0. With no tick, the timer and state hold.
- Light outputs per state:
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_YELLOW: ns=100, ew=010
  - ALL_RED_A/B: both 100
  - Only one direction is ever non-red.
- Request latching:
  - `ped_pending[d]` is set on any clk where `req_d`=1.
  - On entry to d's GREEN: `walk_enable_d` = `ped_pending[d]` | `req_d` for the whole green, and `ped_pending[d]` clears in that same clk.
  - `req_d` in the entry clk is served in this green and is not re-latched.
  - `req_d` during d's GREEN with walk already active is ignored.
  - `req_d` during d's GREEN with walk inactive latches `ped_pending[d]`; it is served at the next d GREEN. No mid-phase walk start.
- `walk_enable_d` deasserts in the clk that d leaves GREEN. It is 0 in every non-green state.
- Reset:
  - State = ALL_RED_B, `master_timer` = ALL_RED_TIME-1.
  - Both lights = 100, walk enables = 0, `ped_pending` = 00.
  - Reset mid-phase aborts immediately to these values. Latched requests are lost.
- Reset has priority over tick, requests and preempt.

Optional Feature:
- Macro: PREEMPT_EN
- With PREEMPT_EN:
  - `preempt` port exists.
  - While `preempt`=1, the next clk enters state PREEMPT regardless of tick or timer.
  - PREEMPT drives both lights 100, walk enables 0 and `master_timer` 0, and holds.
  - On `preempt` falling, enter ALL_RED_B with ALL_RED_TIME-1, then continue normally.
  - `ped_pending` is preserved across preemption; new requests still latch during it.
- Without PREEMPT_EN: no port, no PREEMPT state. Behaviour is exactly the base sequence.

Decomposition:
- Shared package `intersection_pkg`:
  - state encoding constants
  - light encodings RED=3'b100, YELLOW=3'b010, GREEN=3'b001
  - TIMER_W=7
  - duration bounds for elaboration checks
- One natural sub-module, `phase_timer`:
  - 7-bit loadable down-counter gated by `tick`
  - outputs `count` and `expire` (`tick` & count==0)
  - the FSM consumes `expire`.

Test Plan:
- Reset, then run 2 full cycles with a tick every 4 clks -> order ALL_RED_B(2), NS_GREEN(45), NS_YELLOW(4), ALL_RED_A(2), EW_GREEN(45), EW_YELLOW(4), ALL_RED_B(2) ticks; `master_timer` counts 44..0 in green.
- `ns_ped_req` pulse during ALL_RED_A -> `ped_pending`=01 until next NS_GREEN entry; then `ns_walk_enable`=1 for all 45 ticks and `ped_pending`=00; `ew_walk_enable` stays 0.
- `ew_ped_req` asserted exactly on the EW_GREEN entry clk -> walk served this green, `ped_pending[1]` stays 0; pulse at `master_timer`=10 in a non-walk EW green -> latched and served next EW green.
- Reset asserted at `master_timer`=20 in NS_GREEN with `ped_pending`=11 -> next clk ALL_RED_B, timer=1, lights 100/100, pending 00.
- Tick and `req` on the same clk as phase expiry, plus tick held low for 100 clks mid-phase -> correct transition on expiry; state and timer frozen while tick is low.
- (PREEMPT_EN) `preempt` raised at EW_GREEN `master_timer`=30 -> next clk both red, walk 0, timer 0; on release ALL_RED_B timer=1, then NS_GREEN; pending preserved.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection controller slice.
// Holds state encoding, lamp encodings, timer width and duration bounds.
package intersection_pkg;

   localparam int TIMER_W = 7;
   localparam int DUR_MIN = 1;
   localparam int DUR_MAX = 127;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_A = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_B = 3'd5,
      PREEMPT   = 3'd6
   } state_t;

   typedef logic [2:0] light_t;

   localparam light_t RED    = 3'b100;
   localparam light_t YELLOW = 3'b010;
   localparam light_t GREEN  = 3'b001;

   function automatic state_t next_phase(state_t s);
      case (s)
         NS_GREEN:  return NS_YELLOW;
         NS_YELLOW: return ALL_RED_A;
         ALL_RED_A: return EW_GREEN;
         EW_GREEN:  return EW_YELLOW;
         EW_YELLOW: return ALL_RED_B;
         default:   return NS_GREEN;
      endcase
   endfunction

   function automatic light_t ns_light_of(state_t s);
      case (s)
         NS_GREEN:  return GREEN;
         NS_YELLOW: return YELLOW;
         default:   return RED;
      endcase
   endfunction

   function automatic light_t ew_light_of(state_t s);
      case (s)
         EW_GREEN:  return GREEN;
         EW_YELLOW: return YELLOW;
         default:   return RED;
      endcase
   endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Bundle between the intersection controller and its environment.
// master: drives tick/requests(/preempt); slave: drives lamps/timer/walk.
// The preempt wire exists only when PREEMPT_EN is defined.
interface intersection_controller_if;
   import intersection_pkg::*;

   logic                 tick;
   logic                 ns_ped_req;
   logic                 ew_ped_req;
`ifdef PREEMPT_EN
   logic                 preempt;
`endif
   light_t               ns_light;
   light_t               ew_light;
   logic                 ns_walk_enable;
   logic                 ew_walk_enable;
   logic [TIMER_W-1:0]   master_timer;
   logic [1:0]           ped_pending;

   modport master (
`ifdef PREEMPT_EN
      output preempt,
`endif
      output tick, ns_ped_req, ew_ped_req,
      input  ns_light, ew_light,
      input  ns_walk_enable, ew_walk_enable,
      input  master_timer, ped_pending
   );

   modport slave (
`ifdef PREEMPT_EN
      input  preempt,
`endif
      input  tick, ns_ped_req, ew_ped_req,
      output ns_light, ew_light,
      output ns_walk_enable, ew_walk_enable,
      output master_timer, ped_pending
   );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter gated by tick; holds at 0 and never wraps.
// Ports: clk, reset, tick, load, load_val in; count, expire out.
module phase_timer #(
   parameter int           W       = 7,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         expire
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= RST_VAL;
      else if (load)
         count <= load_val;
      else if (tick && count != '0)
         count <= count - W'(1);
   end

   assign expire = tick && (count == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-road signal sequencer: phase FSM, phase timer, walk request latching.
// Ports: clk, reset, bus (slave side). Option: PREEMPT_EN adds preemption.
module intersection_controller
   import intersection_pkg::*;
#(
   parameter int GREEN_TIME   = 45,
   parameter int YELLOW_TIME  = 4,
   parameter int ALL_RED_TIME = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   intersection_controller_if.slave    bus
);

   if (GREEN_TIME < DUR_MIN || GREEN_TIME > DUR_MAX) begin : g_bad_green
      $error("GREEN_TIME out of range");
   end
   if (YELLOW_TIME < DUR_MIN || YELLOW_TIME > DUR_MAX) begin : g_bad_yel
      $error("YELLOW_TIME out of range");
   end
   if (ALL_RED_TIME < DUR_MIN || ALL_RED_TIME > DUR_MAX) begin : g_bad_red
      $error("ALL_RED_TIME out of range");
   end

   localparam logic [TIMER_W-1:0] G_LD = TIMER_W'(GREEN_TIME - 1);
   localparam logic [TIMER_W-1:0] Y_LD = TIMER_W'(YELLOW_TIME - 1);
   localparam logic [TIMER_W-1:0] R_LD = TIMER_W'(ALL_RED_TIME - 1);

   function automatic logic [TIMER_W-1:0] load_of(state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   return G_LD;
         NS_YELLOW, EW_YELLOW: return Y_LD;
         default:              return R_LD;
      endcase
   endfunction

   state_t               state;
   state_t               next_state;
   state_t               succ;
   logic                 load;
   logic [TIMER_W-1:0]   load_val;
   logic [TIMER_W-1:0]   count;
   logic                 expire;

   light_t               ns_q;
   light_t               ew_q;
   logic [1:0]           walk_q;
   logic [1:0]           walk_nxt;
   logic [1:0]           pend_q;
   logic [1:0]           pend_nxt;
   logic                 ns_enter;
   logic                 ew_enter;
   logic                 ns_ign;
   logic                 ew_ign;

   phase_timer #(
      .W       (TIMER_W),
      .RST_VAL (R_LD)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (bus.tick),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .expire   (expire)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= ALL_RED_B;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      load_val   = '0;
      succ       = next_phase(state);
`ifdef PREEMPT_EN
      if (bus.preempt) begin
         next_state = PREEMPT;
         load       = 1'b1;
         load_val   = '0;
      end else if (state == PREEMPT) begin
         next_state = ALL_RED_B;
         load       = 1'b1;
         load_val   = R_LD;
      end else
`endif
      if (expire) begin
         next_state = succ;
         load       = 1'b1;
         load_val   = load_of(succ);
      end
   end

   // A request is dropped only while its own green already has walk on.
   always_comb begin
      ns_enter    = (next_state == NS_GREEN) && (state != NS_GREEN);
      ew_enter    = (next_state == EW_GREEN) && (state != EW_GREEN);
      ns_ign      = (state == NS_GREEN) && walk_q[0];
      ew_ign      = (state == EW_GREEN) && walk_q[1];
      pend_nxt[0] = ns_enter ? 1'b0
                  : pend_q[0] | (bus.ns_ped_req & ~ns_ign);
      pend_nxt[1] = ew_enter ? 1'b0
                  : pend_q[1] | (bus.ew_ped_req & ~ew_ign);
      walk_nxt[0] = ns_enter ? (pend_q[0] | bus.ns_ped_req)
                  : (next_state == NS_GREEN) & walk_q[0];
      walk_nxt[1] = ew_enter ? (pend_q[1] | bus.ew_ped_req)
                  : (next_state == EW_GREEN) & walk_q[1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ns_q   <= RED;
         ew_q   <= RED;
         walk_q <= 2'b00;
         pend_q <= 2'b00;
      end else begin
         ns_q   <= ns_light_of(next_state);
         ew_q   <= ew_light_of(next_state);
         walk_q <= walk_nxt;
         pend_q <= pend_nxt;
      end
   end

   assign bus.ns_light       = ns_q;
   assign bus.ew_light       = ew_q;
   assign bus.ns_walk_enable = walk_q[0];
   assign bus.ew_walk_enable = walk_q[1];
   assign bus.master_timer   = count;
   assign bus.ped_pending    = pend_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: phase-table model
// compared every clk, plus directed literal checks.
module tb_intersection_controller;

   localparam int GT = 45;
   localparam int YT = 4;
   localparam int AT = 2;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pre_lvl = 1'b0;
   int   checks = 0;
   int   errors = 0;

   intersection_controller_if bus();

   intersection_controller #(
      .GREEN_TIME   (GT),
      .YELLOW_TIME  (YT),
      .ALL_RED_TIME (AT)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Phase table: 0 NSG,1 NSY,2 ARA,3 EWG,4 EWY,5 ARB
   int         dur [6]    = '{GT, YT, AT, GT, YT, AT};
   logic [2:0] ns_tab [6] = '{G, Y, R, R, R, R};
   logic [2:0] ew_tab [6] = '{R, R, R, G, Y, R};

   int       m_ph, m_rem, o_ph, gp;
   bit       m_pre, o_pre, m_valid, in_g, ent;
   bit [1:0] m_walk, m_pend, rq, ign;
   logic [2:0] e_ns, e_ew;
   logic [6:0] e_tm;

   always @(posedge clk) begin
      rq = {bus.ew_ped_req, bus.ns_ped_req};
      if (rst) begin
         m_ph = 5; m_rem = AT - 1; m_pre = 0;
         m_walk = 0; m_pend = 0; m_valid = 1;
      end else begin
         o_ph = m_ph;
         o_pre = m_pre;
         ign[0] = !o_pre && o_ph == 0 && m_walk[0];
         ign[1] = !o_pre && o_ph == 3 && m_walk[1];
         if (pre_lvl) begin
            m_pre = 1; m_rem = 0;
         end else if (m_pre) begin
            m_pre = 0; m_ph = 5; m_rem = AT - 1;
         end else if (bus.tick) begin
            if (m_rem == 0) begin
               m_ph = (m_ph + 1) % 6;
               m_rem = dur[m_ph] - 1;
            end else begin
               m_rem = m_rem - 1;
            end
         end
         for (int d = 0; d < 2; d++) begin
            gp = (d == 0) ? 0 : 3;
            in_g = !m_pre && m_ph == gp;
            ent = in_g && (o_pre || o_ph != gp);
            if (ent) begin
               m_walk[d] = m_pend[d] | rq[d];
               m_pend[d] = 0;
            end else begin
               if (!in_g) m_walk[d] = 0;
               if (rq[d] && !ign[d]) m_pend[d] = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         e_ns = m_pre ? R : ns_tab[m_ph];
         e_ew = m_pre ? R : ew_tab[m_ph];
         e_tm = 7'(m_rem);
         checks++;
         if ({bus.ns_light, bus.ew_light, bus.ns_walk_enable,
              bus.ew_walk_enable, bus.master_timer, bus.ped_pending}
             !== {e_ns, e_ew, m_walk[0], m_walk[1], e_tm, m_pend}) begin
            errors++;
            $display("FAIL model t=%0t got ns=%b ew=%b wn=%b we=%b tm=%0d pd=%b req ns=%b ew=%b wn=%b we=%b tm=%0d pd=%b",
                     $time, bus.ns_light, bus.ew_light,
                     bus.ns_walk_enable, bus.ew_walk_enable,
                     bus.master_timer, bus.ped_pending,
                     e_ns, e_ew, m_walk[0], m_walk[1], e_tm, m_pend);
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(bit t, bit nr, bit er);
      bus.tick = t;
      bus.ns_ped_req = nr;
      bus.ew_ped_req = er;
`ifdef PREEMPT_EN
      bus.preempt = pre_lvl;
`endif
      @(posedge clk);
      #1;
      bus.tick = 0;
      bus.ns_ped_req = 0;
      bus.ew_ped_req = 0;
   endtask

   task automatic ticks(int n);
      repeat (n) begin
         repeat (3) cyc(0, 0, 0);
         cyc(1, 0, 0);
      end
   endtask

   function automatic logic [31:0] lt();
      return {19'd0, bus.ns_light, bus.ew_light, bus.master_timer};
   endfunction

   function automatic logic [31:0] wp();
      return {28'd0, bus.ns_walk_enable, bus.ew_walk_enable,
              bus.ped_pending};
   endfunction

   initial begin
      bus.tick = 0;
      bus.ns_ped_req = 0;
      bus.ew_ped_req = 0;
`ifdef PREEMPT_EN
      bus.preempt = 0;
`endif
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      chk("reset_lt", lt(), {19'd0, R, R, 7'd1});
      chk("reset_wp", wp(), 32'h0);

      ticks(2);
      chk("ns_green_entry", lt(), {19'd0, G, R, 7'd44});
      ticks(45);
      chk("ns_yellow", lt(), {19'd0, Y, R, 7'd3});
      ticks(4);
      chk("all_red_a", lt(), {19'd0, R, R, 7'd1});
      cyc(0, 1, 0);
      chk("ns_req_latch", wp(), {28'd0, 4'b0001});
      ticks(2);
      chk("ew_green_entry", lt(), {19'd0, R, G, 7'd44});
      chk("ew_green_nowalk", wp(), {28'd0, 4'b0001});
      ticks(34);
      chk("ew_tm10", lt(), {19'd0, R, G, 7'd10});
      cyc(0, 0, 1);
      chk("ew_req_latch", wp(), {28'd0, 4'b0011});
      ticks(11);
      chk("ew_yellow", lt(), {19'd0, R, Y, 7'd3});
      ticks(4);
      chk("all_red_b", lt(), {19'd0, R, R, 7'd1});
      ticks(2);
      chk("ns_walk_on", wp(), {28'd0, 4'b1010});
      chk("ns_green2", lt(), {19'd0, G, R, 7'd44});
      ticks(45);
      chk("ns_walk_off", wp(), {28'd0, 4'b0010});
      ticks(5);
      chk("ara_tm0", lt(), {19'd0, R, R, 7'd0});
      cyc(1, 0, 1);
      chk("ew_entry_req", wp(), {28'd0, 4'b0100});
      chk("ew_entry_lt", lt(), {19'd0, R, G, 7'd44});
      ticks(10);
      cyc(0, 0, 1);
      chk("ew_req_ignored", wp(), {28'd0, 4'b0100});
      ticks(34);
      cyc(1, 0, 1);
      chk("ew_exit_lt", lt(), {19'd0, R, Y, 7'd3});
      chk("ew_exit_wp", wp(), {28'd0, 4'b0000});
      repeat (100) cyc(0, 0, 0);
      chk("hold_no_tick", lt(), {19'd0, R, Y, 7'd3});
      cyc(0, 0, 1);
      ticks(6);
      chk("ns_g_nowalk", wp(), {28'd0, 4'b0010});
      ticks(24);
      cyc(0, 1, 0);
      chk("ns_g_tm20", lt(), {19'd0, G, R, 7'd20});
      chk("pend_11", wp(), {28'd0, 4'b0011});
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      chk("midrst_lt", lt(), {19'd0, R, R, 7'd1});
      chk("midrst_wp", wp(), 32'h0);

`ifdef PREEMPT_EN
      ticks(2 + 45 + 4 + 2);
      cyc(0, 1, 0);
      ticks(14);
      chk("pre_ew_tm30", lt(), {19'd0, R, G, 7'd30});
      pre_lvl = 1;
      cyc(0, 0, 0);
      chk("pre_lt", lt(), {19'd0, R, R, 7'd0});
      chk("pre_wp", wp(), {28'd0, 4'b0001});
      ticks(3);
      cyc(0, 0, 1);
      chk("pre_latch", wp(), {28'd0, 4'b0011});
      pre_lvl = 0;
      cyc(0, 0, 0);
      chk("pre_rel_lt", lt(), {19'd0, R, R, 7'd1});
      ticks(2);
      chk("pre_ns_green", lt(), {19'd0, G, R, 7'd44});
      chk("pre_ns_walk", wp(), {28'd0, 4'b1010});
`endif

      repeat (3) cyc(0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
